call_request_bank: RTL and testbench

- Parametrised successor of the cabin/hall button register for the elevator controller.
- Conditions raw cabin (in), hall-up and hall-down buttons for FLOORS floors with a 2-flop synchroniser and a per-button debounce counter, then edge-detects each press.
- Keeps one request bit per button, with cabin toggle-cancel, current-floor blocking and service-clear.
- Feeds the floor scheduler with request vectors, direction summaries and a pending-request count.

---
 rtl/call_request_bank_if.sv | 38 +++
 rtl/call_request_bank.sv | 122 ++++++++++++
 tb/tb_call_request_bank.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/call_request_bank_if.sv
// Button/clear inputs and request outputs between the call-request bank and the floor scheduler.
// master = scheduler/driver side, slave = call_request_bank.
interface call_request_bank_if #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
);
    localparam int PC_W = $clog2(3*FLOORS+1);

    logic [FLOOR_W-1:0] cur_floor;
    logic               car_stopped;
    logic [FLOORS-1:0]  btn_in;
    logic [FLOORS-1:0]  btn_up_out;
    logic [FLOORS-1:0]  btn_down_out;
    logic [FLOORS-1:0]  clr_in;
    logic [FLOORS-1:0]  clr_up;
    logic [FLOORS-1:0]  clr_down;
    logic [FLOORS-1:0]  active_in_levels;
    logic [FLOORS-1:0]  active_out_up_levels;
    logic [FLOORS-1:0]  active_out_down_levels;
    logic               any_above;
    logic               any_below;
    logic               any_here;
    logic [PC_W-1:0]    pending_count;

    modport master (
        output cur_floor, car_stopped, btn_in, btn_up_out, btn_down_out,
               clr_in, clr_up, clr_down,
        input  active_in_levels, active_out_up_levels, active_out_down_levels,
               any_above, any_below, any_here, pending_count
    );

    modport slave (
        input  cur_floor, car_stopped, btn_in, btn_up_out, btn_down_out,
               clr_in, clr_up, clr_down,
        output active_in_levels, active_out_up_levels, active_out_down_levels,
               any_above, any_below, any_here, pending_count
    );
endinterface

// File: rtl/call_request_bank.sv
// Cabin/hall request bank: sync + debounce + edge-detect per button, request bits, direction summaries.
// BTN_DEBOUNCE_EN adds debounce counters (press-to-active DEBOUNCE_CYCLES+3 edges, else 3 edges).
module call_request_bank #(
    parameter int FLOORS          = 8,
    parameter int FLOOR_W         = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic               clk,
    input  logic               reset,
    call_request_bank_if.slave bus
);
    localparam int PC_W = $clog2(3*FLOORS+1);
    localparam int NCH  = 3*FLOORS;
    localparam logic [FLOORS-1:0] UP_OK   = ~(FLOORS'(1) << (FLOORS-1));
    localparam logic [FLOORS-1:0] DOWN_OK = ~FLOORS'(1);

    generate
        if (DEBOUNCE_CYCLES < 1 || (2**CNT_W) <= DEBOUNCE_CYCLES || (2**FLOOR_W) < FLOORS) begin : g_bad_cfg
            $error("call_request_bank: inconsistent FLOORS/FLOOR_W/DEBOUNCE_CYCLES/CNT_W");
        end
    endgenerate

    logic [NCH-1:0]    raw, sync1, sync2, deb, deb_d, press;
    logic [FLOORS-1:0] ev_in, ev_up, ev_down;
    logic [FLOORS-1:0] act_in, act_up, act_down, blocked;
    logic [PC_W-1:0]   pend, pend_nxt;
    logic [31:0]       cur_ext;
    logic              above, below, here;

    assign raw = {bus.btn_down_out, bus.btn_up_out, bus.btn_in};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb_d <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt [NCH];
    logic [NCH-1:0]   deb_q;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            deb_q <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == deb_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES-1)) begin
                    deb_q[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end
    assign deb = deb_q;
`else
    assign deb = sync2;
`endif

    assign press   = deb & ~deb_d;
    assign ev_in   = press[FLOORS-1:0];
    assign ev_up   = press[2*FLOORS-1:FLOORS];
    assign ev_down = press[3*FLOORS-1:2*FLOORS];
    assign cur_ext = 32'(bus.cur_floor);

    always_comb begin
        blocked = '0;
        above   = 1'b0;
        below   = 1'b0;
        here    = 1'b0;
        for (int f = 0; f < FLOORS; f++) begin
            blocked[f] = bus.car_stopped && (bus.cur_floor == FLOOR_W'(f));
            if (32'(f) > cur_ext)
                above = above | act_in[f] | act_up[f] | act_down[f];
            else if (32'(f) == cur_ext)
                here = here | act_in[f] | act_up[f] | act_down[f];
            else
                below = below | act_in[f] | act_up[f] | act_down[f];
        end
    end

    always_comb begin
        pend_nxt = '0;
        for (int f = 0; f < FLOORS; f++)
            pend_nxt = pend_nxt + PC_W'(act_in[f]) + PC_W'(act_up[f]) + PC_W'(act_down[f]);
    end

    // Clear dominates a same-cycle press; cabin presses toggle, hall presses only set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            act_in   <= '0;
            act_up   <= '0;
            act_down <= '0;
            pend     <= '0;
        end else begin
            act_in   <= (act_in ^ (ev_in & ~blocked)) & ~bus.clr_in;
            act_up   <= (act_up | (ev_up & ~blocked)) & ~bus.clr_up & UP_OK;
            act_down <= (act_down | (ev_down & ~blocked)) & ~bus.clr_down & DOWN_OK;
            pend     <= pend_nxt;
        end
    end

    assign bus.active_in_levels       = act_in;
    assign bus.active_out_up_levels   = act_up;
    assign bus.active_out_down_levels = act_down;
    assign bus.any_above              = above;
    assign bus.any_below              = below;
    assign bus.any_here               = here;
    assign bus.pending_count          = pend;
endmodule

// File: tb/tb_call_request_bank.sv
// Bench for call_request_bank: directed steps plus random buttons/clears/floors, compared every cycle
// against a window-based reference model; works with or without BTN_DEBOUNCE_EN.
module tb_call_request_bank;
    localparam int F   = 8;
    localparam int FW  = 3;
    localparam int D   = 4;
`ifdef BTN_DEBOUNCE_EN
    localparam int LAT = D + 3;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_chk  = 0;

    call_request_bank_if #(.FLOORS(F), .FLOOR_W(FW)) bus ();

    call_request_bank #(.FLOORS(F), .FLOOR_W(FW), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: raw sample history (newest first), debounced level, requests.
    logic [3*F-1:0] hq[$];
    logic [3*F-1:0] m_deb, m_dprev;
    logic [F-1:0]   m_in, m_up, m_down;
    int             m_pc;

    function automatic logic [3*F-1:0] hist_at(int ago);
        if (ago < hq.size()) return hq[ago];
        return '0;
    endfunction

    task automatic model_edge();
        logic [3*F-1:0] dt, ev, s;
        logic           all_diff;
        if (!reset) begin
            hq.delete();
            m_deb = '0; m_dprev = '0;
            m_in = '0; m_up = '0; m_down = '0; m_pc = 0;
            return;
        end
        hq.push_front({bus.btn_down_out, bus.btn_up_out, bus.btn_in});
        if (hq.size() > D + 4) void'(hq.pop_back());
`ifdef BTN_DEBOUNCE_EN
        // Level seen by the edge detector is the debounced level held before this edge; it flips
        // once the last D synchronised samples (raw from 2..D+1 edges ago) all disagree with it.
        dt = m_deb;
        for (int ch = 0; ch < 3*F; ch++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) begin
                s = hist_at(2 + k);
                if (s[ch] == m_deb[ch]) all_diff = 1'b0;
            end
            if (all_diff) m_deb[ch] = ~m_deb[ch];
        end
`else
        dt = hist_at(2);
`endif
        ev      = dt & ~m_dprev;
        m_dprev = dt;
        m_pc    = $countones({m_in, m_up, m_down});
        for (int f = 0; f < F; f++) begin
            logic blk;
            blk = bus.car_stopped && (int'(bus.cur_floor) == f);
            if (bus.clr_in[f])              m_in[f] = 1'b0;
            else if (ev[f] && !blk)         m_in[f] = ~m_in[f];
            if (bus.clr_up[f])              m_up[f] = 1'b0;
            else if (ev[F+f] && !blk && f != F-1) m_up[f] = 1'b1;
            if (bus.clr_down[f])            m_down[f] = 1'b0;
            else if (ev[2*F+f] && !blk && f != 0) m_down[f] = 1'b1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic compare_all();
        logic ab, bl, hr, h;
        ab = 1'b0; bl = 1'b0; hr = 1'b0;
        for (int f = 0; f < F; f++) begin
            h = m_in[f] | m_up[f] | m_down[f];
            if (f > int'(bus.cur_floor))       ab |= h;
            else if (f == int'(bus.cur_floor)) hr |= h;
            else                               bl |= h;
        end
        chk("active_in", 32'(bus.active_in_levels), 32'(m_in));
        chk("active_up", 32'(bus.active_out_up_levels), 32'(m_up));
        chk("active_down", 32'(bus.active_out_down_levels), 32'(m_down));
        chk("pending_count", 32'(bus.pending_count), 32'(m_pc));
        chk("any_above", 32'(bus.any_above), 32'(ab));
        chk("any_below", 32'(bus.any_below), 32'(bl));
        chk("any_here", 32'(bus.any_here), 32'(hr));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic release_all();
        bus.btn_in = '0; bus.btn_up_out = '0; bus.btn_down_out = '0;
        run(LAT + 4);
    endtask

    task automatic clear_all();
        bus.clr_in = '1; bus.clr_up = '1; bus.clr_down = '1;
        cycle();
        bus.clr_in = '0; bus.clr_up = '0; bus.clr_down = '0;
        cycle();
    endtask

    initial begin
        reset = 1'b0;
        bus.cur_floor = '0; bus.car_stopped = 1'b0;
        bus.btn_in = '1; bus.btn_up_out = '1; bus.btn_down_out = '1;
        bus.clr_in = '0; bus.clr_up = '0; bus.clr_down = '0;

        // Reset with every button held, then latency of the first requests.
        run(2);
        chk("reset_pending", 32'(bus.pending_count), 32'd0);
        reset = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            cycle();
            if (e == LAT - 1) chk("pre_latency_in", 32'(bus.active_in_levels), 32'h00);
            if (e == LAT) begin
                chk("lat_in", 32'(bus.active_in_levels), 32'hFF);
                chk("lat_up", 32'(bus.active_out_up_levels), 32'h7F);
                chk("lat_down", 32'(bus.active_out_down_levels), 32'hFE);
            end
            if (e == LAT + 1) chk("pending_full", 32'(bus.pending_count), 32'd22);
        end
        release_all();
        clear_all();

`ifdef BTN_DEBOUNCE_EN
        // Short glitch rejected, long press toggles on, second long press toggles off.
        bus.btn_in[3] = 1'b1; run(3);
        bus.btn_in[3] = 1'b0; run(12);
        chk("glitch_rejected", 32'(bus.active_in_levels), 32'h00);
        bus.btn_in[3] = 1'b1; run(6);
        chk("press_edge6", 32'(bus.active_in_levels), 32'h00);
        cycle();
        chk("press_edge7", 32'(bus.active_in_levels), 32'h08);
        run(3);
        bus.btn_in[3] = 1'b0; run(12);
        bus.btn_in[3] = 1'b1; run(10);
        bus.btn_in[3] = 1'b0; run(12);
        chk("toggle_cancel", 32'(bus.active_in_levels), 32'h00);
`else
        // Without debounce a single-cycle pulse becomes a request at edge 3.
        bus.btn_in[1] = 1'b1; cycle();
        bus.btn_in[1] = 1'b0; cycle();
        chk("pulse_edge2", 32'(bus.active_in_levels), 32'h00);
        cycle();
        chk("pulse_edge3", 32'(bus.active_in_levels), 32'h02);
        run(4);
        clear_all();
`endif

        // Presses at the floor where the car stands are ignored.
        bus.car_stopped = 1'b1; bus.cur_floor = 3'd2;
        bus.btn_in[2] = 1'b1; bus.btn_up_out[2] = 1'b1;
        run(LAT + 3);
        chk("blocked_in", 32'(bus.active_in_levels), 32'h00);
        chk("blocked_up", 32'(bus.active_out_up_levels), 32'h00);
        release_all();
        bus.car_stopped = 1'b0;
        bus.btn_in[2] = 1'b1; bus.btn_up_out[2] = 1'b1;
        run(LAT + 1);
        chk("unblocked_in", 32'(bus.active_in_levels), 32'h04);
        chk("unblocked_up", 32'(bus.active_out_up_levels), 32'h04);
        chk("unblocked_here", 32'(bus.any_here), 32'd1);
        release_all();
        clear_all();

        // Direction summaries and service-clear.
        bus.cur_floor = 3'd0;
        bus.btn_up_out[4] = 1'b1; bus.btn_up_out[5] = 1'b1;
        run(LAT + 1);
        bus.cur_floor = 3'd4;
        release_all();
        chk("up_30", 32'(bus.active_out_up_levels), 32'h30);
        chk("dir_above", 32'(bus.any_above), 32'd1);
        chk("dir_here", 32'(bus.any_here), 32'd1);
        chk("dir_below", 32'(bus.any_below), 32'd0);
        chk("pending_two", 32'(bus.pending_count), 32'd2);
        bus.clr_up = 8'h30; cycle();
        bus.clr_up = '0;
        chk("cleared_up", 32'(bus.active_out_up_levels), 32'h00);
        chk("cleared_above", 32'(bus.any_above), 32'd0);
        chk("pending_lags", 32'(bus.pending_count), 32'd2);
        cycle();
        chk("pending_dropped", 32'(bus.pending_count), 32'd0);

        // Clear beats a same-cycle press; boundary hall buttons never register.
        bus.btn_down_out[6] = 1'b1;
        run(LAT - 1);
        bus.clr_down[6] = 1'b1; cycle();
        bus.clr_down[6] = 1'b0; run(4);
        chk("clear_wins", 32'(bus.active_out_down_levels), 32'h00);
        release_all();
        bus.btn_up_out[7] = 1'b1; bus.btn_down_out[0] = 1'b1;
        run(LAT + 2);
        chk("boundary_up", 32'(bus.active_out_up_levels), 32'h00);
        chk("boundary_down", 32'(bus.active_out_down_levels), 32'h00);
        release_all();

        // Random traffic including mid-operation resets.
        for (int c = 0; c < 1500; c++) begin
            logic [3*F-1:0] r;
            r = {bus.btn_down_out, bus.btn_up_out, bus.btn_in};
            if ($urandom_range(0, 2) == 0) begin
                int ch;
                ch = $urandom_range(0, 3*F-1);
                r[ch] = ~r[ch];
            end
            {bus.btn_down_out, bus.btn_up_out, bus.btn_in} = r;
            if ($urandom_range(0, 15) == 0) begin
                bus.clr_in   = F'($urandom) & F'($urandom);
                bus.clr_up   = F'($urandom) & F'($urandom);
                bus.clr_down = F'($urandom) & F'($urandom);
            end else begin
                bus.clr_in = '0; bus.clr_up = '0; bus.clr_down = '0;
            end
            if ($urandom_range(0, 9) == 0) bus.car_stopped = 1'($urandom);
            if ($urandom_range(0, 9) == 0) bus.cur_floor = FW'($urandom);
            reset = ($urandom_range(0, 299) != 0);
            cycle();
        end
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
